// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and helpers for the multi-channel key debouncer.
//   clog2()                    constant ceiling-log2, used for counter widths
//   DEB_SAMPLE_DEFAULT         default stability window (cycles)
//   DEB_REPEAT_DELAY_DEFAULT   default delay before the first auto-repeat (cycles)
//   DEB_REPEAT_PERIOD_DEFAULT  default spacing of later auto-repeats (cycles)
`timescale 1ns/1ps
package debounce_pkg;

  localparam int unsigned DEB_SAMPLE_DEFAULT        = 32'h000F_FFFF;
  localparam int unsigned DEB_REPEAT_DELAY_DEFAULT  = 32'h00FF_FFFF;
  localparam int unsigned DEB_REPEAT_PERIOD_DEFAULT = 32'h003F_FFFF;

  // Smallest r with 2**r >= v. Callers pass MAX+1, so the result can hold MAX.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one debounced key.
//   2-flop synchroniser -> single up-counter stability filter -> registered
//   level with one-cycle rise/fall pulses. Optional auto-repeat pulses while
//   the level is held high, enabled by the macro DEBOUNCE_REPEAT_EN.
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   key_i   raw asynchronous input
//   level_o debounced level
//   rise_o  one-cycle pulse when level_o goes 0->1
//   fall_o  one-cycle pulse when level_o goes 1->0
//   rpt_o   auto-repeat pulse (constant 0 without DEBOUNCE_REPEAT_EN)
`timescale 1ns/1ps
module debounce_channel import debounce_pkg::*; #(
  parameter int unsigned SAMPLE_TIME   = DEB_SAMPLE_DEFAULT,
  parameter int unsigned CNT_W         = clog2(SAMPLE_TIME + 1)
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = DEB_REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD = DEB_REPEAT_PERIOD_DEFAULT
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic rpt_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_TIME - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // The counter only runs while the synchronised input disagrees with the
  // stable level; any agreement throws the partial count away.
  always_comb begin
    s1_d    = key_i;
    s2_d    = s1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rcnt_q, rcnt_d;
  logic             first_q, first_d;
  logic             rpt_q, rpt_d;
  logic [RPT_W-1:0] rpt_lim;

  // Decisions use the next-cycle level/rise so the counter starts in the same
  // cycle the rise pulse appears, and a fall suppresses a repeat that would
  // otherwise coincide with it.
  always_comb begin
    rcnt_d  = rcnt_q;
    first_d = first_q;
    rpt_d   = 1'b0;
    rpt_lim = first_q ? RPT_DLY_LAST : RPT_PER_LAST;
    if (!level_d || rise_d) begin
      rcnt_d  = '0;
      first_d = 1'b1;
    end else if (rcnt_q == rpt_lim) begin
      rpt_d   = 1'b1;
      rcnt_d  = '0;
      first_d = 1'b0;
    end else begin
      rcnt_d = rcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q  <= '0;
      first_q <= 1'b1;
      rpt_q   <= 1'b0;
    end else begin
      rcnt_q  <= rcnt_d;
      first_q <= first_d;
      rpt_q   <= rpt_d;
    end
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_array.sv
// debounce_array: NUM_CH independent key debouncers plus a shared event flag.
//   Optional auto-repeat is enabled by defining DEBOUNCE_REPEAT_EN; otherwise
//   key_rpt is constant 0 and REPEAT_* only take part in the parameter check.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   key_in     raw asynchronous inputs [NUM_CH]
//   key_out    debounced levels
//   key_rise   one-cycle 0->1 pulses
//   key_fall   one-cycle 1->0 pulses
//   key_rpt    auto-repeat pulses
//   any_event  registered OR of all pulses, one cycle after them
`timescale 1ns/1ps
module debounce_array import debounce_pkg::*; #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SAMPLE_TIME   = DEB_SAMPLE_DEFAULT,
  parameter int unsigned CNT_W         = clog2(SAMPLE_TIME + 1),
  parameter int unsigned REPEAT_DELAY  = DEB_REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD = DEB_REPEAT_PERIOD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] key_in,
  output logic [NUM_CH-1:0] key_out,
  output logic [NUM_CH-1:0] key_rise,
  output logic [NUM_CH-1:0] key_fall,
  output logic [NUM_CH-1:0] key_rpt,
  output logic              any_event
);

  // Zero-length windows or channel counts have no meaningful implementation.
  if (NUM_CH < 1 || SAMPLE_TIME < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("debounce_array: NUM_CH, SAMPLE_TIME, REPEAT_DELAY and REPEAT_PERIOD must all be >= 1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SAMPLE_TIME   (SAMPLE_TIME),
      .CNT_W         (CNT_W)
`ifdef DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .key_i   (key_in[i]),
      .level_o (key_out[i]),
      .rise_o  (key_rise[i]),
      .fall_o  (key_fall[i]),
      .rpt_o   (key_rpt[i])
    );
  end

  logic any_event_q, any_event_d;

  always_comb begin
    any_event_d = |(key_rise | key_fall | key_rpt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_event_q <= 1'b0;
    else     any_event_q <= any_event_d;
  end

  assign any_event = any_event_q;

endmodule

// File: tb/tb_debounce_array.sv
`timescale 1ns/1ps
module tb_debounce_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_out, key_rise, key_fall, key_rpt;
  logic       any_event;

  int checks   = 0;
  int failures = 0;

`ifdef DEBOUNCE_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  debounce_array #(
    .NUM_CH        (4),
    .SAMPLE_TIME   (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_out   (key_out),
    .key_rise  (key_rise),
    .key_fall  (key_fall),
    .key_rpt   (key_rpt),
    .any_event (any_event)
  );

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_rpt;

    // Reset with all keys pressed
    rst    = 1'b1;
    key_in = 4'hF;
    repeat (3) tick();
    chk("rst_out",  key_out,   4'h0);
    chk("rst_rise", key_rise,  4'h0);
    chk("rst_fall", key_fall,  4'h0);
    chk("rst_rpt",  key_rpt,   4'h0);
    chk("rst_any",  any_event, 1'b0);

    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("rel_wait_out",  key_out,  4'h0);
      chk("rel_wait_rise", key_rise, 4'h0);
    end
    tick();
    chk("rel_out6",  key_out,   4'hF);
    chk("rel_rise6", key_rise,  4'hF);
    chk("rel_any6",  any_event, 1'b0);
    tick();
    chk("rel_rise7", key_rise,  4'h0);
    chk("rel_any7",  any_event, 1'b1);
    tick();
    chk("rel_any8",  any_event, 1'b0);

    // Bring ch0 low so it can be glitched
    key_in = 4'hE;
    repeat (5) tick();
    tick();
    chk("ch0_fall", key_fall, 4'h1);
    chk("ch0_low",  key_out,  4'hE);
    tick();
    chk("ch0_fall_end", key_fall, 4'h0);

    // 3-cycle glitch on ch0 must be rejected
    key_in[0] = 1'b1;
    repeat (3) tick();
    key_in[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("glitch_out",  key_out,  4'hE);
      chk("glitch_rise", key_rise, 4'h0);
    end

    // Genuine press on ch0
    key_in[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("press_wait", key_out, 4'hE);
    end
    tick();
    chk("press_out",  key_out,  4'hF);
    chk("press_rise", key_rise, 4'h1);
    tick();
    chk("press_rise_end", key_rise, 4'h0);

    // Release ch1
    key_in = 4'b1101;
    repeat (5) tick();
    tick();
    chk("ch1_fall", key_fall, 4'h2);
    chk("ch1_out",  key_out,  4'hD);
    tick();
    chk("ch1_fall_end", key_fall, 4'h0);
    chk("ch1_out_hold", key_out,  4'hD);

    // ch2 toggles, ch3 held high and must stay untouched
    key_in = 4'b1001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("ind_ch3_out", key_out[3], 1'b1);
      chk("ind_ch3_pls", key_rise[3] | key_fall[3], 1'b0);
      if (k == 6) chk("ind_ch2_fall", key_fall, 4'b0100);
    end
    key_in = 4'b1101;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("ind_ch3_out", key_out[3], 1'b1);
      chk("ind_ch3_pls", key_rise[3] | key_fall[3], 1'b0);
      if (k == 6) chk("ind_ch2_rise", key_rise, 4'b0100);
    end

    // Simultaneous steps on ch0 and ch3
    key_in = 4'b0100;
    repeat (5) tick();
    tick();
    chk("sim_fall", key_fall, 4'b1001);
    chk("sim_fall_out", key_out, 4'b0100);
    key_in = 4'b1101;
    repeat (5) tick();
    tick();
    chk("sim_rise", key_rise, 4'b1001);
    chk("sim_rise_out", key_out, 4'b1101);
    tick();
    chk("sim_rise_end", key_rise, 4'h0);
    chk("sim_any", any_event, 1'b1);

    // Reset in the middle of a count
    rst    = 1'b1;
    key_in = 4'h0;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("mid_clear", key_out, 4'h0);
    key_in = 4'b0001;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_out",  key_out,  4'h0);
    chk("mid_rst_rise", key_rise, 4'h0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("mid_wait_out",  key_out,  4'h0);
      chk("mid_wait_rise", key_rise, 4'h0);
    end
    tick();
    chk("mid_out",  key_out,  4'h1);
    chk("mid_rise", key_rise, 4'h1);

    // Auto-repeat while ch0 is held (rise was at tick 0)
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_rpt = RPT_ON && (k == 10 || k == 13 || k == 16);
      chk("rpt_hold", key_rpt, {3'b000, exp_rpt});
    end
    key_in = 4'h0;
    for (int k = 17; k <= 30; k++) begin
      tick();
      exp_rpt = RPT_ON && (k == 19);
      chk("rpt_release", key_rpt, {3'b000, exp_rpt});
      if (k == 22) chk("rpt_fall", key_fall, 4'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
